// File: rtl/conv_quant_ctrl_11_pkg.sv
// Shared geometry, FSM encoding and saturation helper for the
// requantize stage that follows the 1x1-conv bias add.
package conv_quant_ctrl_11_pkg;

    localparam int PICTURE_NUM           = 2;
    localparam int CHANNEL_OUT_NUM       = 8;
    localparam int WIDTH_FEATURE_SIZE    = 12;
    localparam int WIDTH_DATA_ADD_TEMP   = 48;
    localparam int WIDTH_SCALE           = 32;
    localparam int WIDTH_CHANNEL_NUM_REG = 10;
    localparam int BIAS_LAT              = 2;
    localparam int LANE_NUM              = PICTURE_NUM * CHANNEL_OUT_NUM;
    localparam int WIDTH_PROD            = WIDTH_DATA_ADD_TEMP + WIDTH_SCALE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PARAM,
        S_WAIT,
        S_READ,
        S_DRAIN,
        S_NEXT,
        S_FIN
    } state_t;

    function automatic logic [7:0] clamp_u8(input logic signed [WIDTH_PROD:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/conv_quant_ctrl_11_lane.sv
// One requantize lane: scale multiply, rounding arithmetic shift,
// zero-point add and uint8 saturation, one register per step.
module conv_quant_ctrl_11_lane
    import conv_quant_ctrl_11_pkg::*;
(
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [2:0]                            i_en,
    input  logic signed [WIDTH_DATA_ADD_TEMP-1:0] i_data,
    input  logic signed [WIDTH_SCALE-1:0]         i_scale,
    input  logic [5:0]                            i_shift,
    input  logic [7:0]                            i_zp,
    output logic [7:0]                            o_data
);

    logic signed [WIDTH_PROD-1:0] r_p;
    logic signed [WIDTH_PROD-1:0] r_r;
    logic [7:0]                   r_q;
    logic signed [WIDTH_PROD-1:0] w_rnd;
    logic signed [WIDTH_PROD-1:0] w_r;
    logic signed [WIDTH_PROD:0]   w_q;

    // Half-LSB bias gives round-half-up after the arithmetic shift.
    assign w_rnd = (i_shift == 6'd0) ? '0
                 : (WIDTH_PROD'(1) << (i_shift - 6'd1));
    assign w_r   = (r_p + w_rnd) >>> i_shift;
    assign w_q   = {r_r[WIDTH_PROD-1], r_r}
                 + {{(WIDTH_PROD-7){1'b0}}, i_zp};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_p <= '0;
            r_r <= '0;
            r_q <= '0;
        end else begin
            if (i_en[0])
                r_p <= WIDTH_PROD'(i_data) * WIDTH_PROD'(i_scale);
            if (i_en[1])
                r_r <= w_r;
            if (i_en[2])
                r_q <= clamp_u8(w_q);
        end
    end

    assign o_data = r_q;

endmodule

// File: rtl/conv_quant_ctrl_11.sv
// Requantize controller: row-burst reads from the bias FIFO, per-group
// parameter addressing and a 3-stage quantize pipe per lane.
module conv_quant_ctrl_11
    import conv_quant_ctrl_11_pkg::*;
(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          Start,
    input  logic                                          fifo_ready,
    output logic                                          rd_en_fifo,
    input  logic [LANE_NUM*WIDTH_DATA_ADD_TEMP-1:0]       S_Data,
    output logic [WIDTH_CHANNEL_NUM_REG-1:0]              Param_Addr,
    input  logic [WIDTH_SCALE*CHANNEL_OUT_NUM-1:0]        Scale_Data_in,
    input  logic [5:0]                                    Shift_REG,
    input  logic [7:0]                                    Zero_Point_REG,
    input  logic [WIDTH_CHANNEL_NUM_REG-1:0]              Channel_Out_Num_REG,
    input  logic [WIDTH_FEATURE_SIZE-1:0]                 Row_Num_Out_REG,
    input  logic                                          M_Ready,
    output logic [LANE_NUM*8-1:0]                         M_Data,
    output logic                                          M_Valid,
    output logic                                          Layer_Done
);

    state_t                           r_state;
    state_t                           w_next;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] r_ct;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] r_grp;
    logic [WIDTH_FEATURE_SIZE-1:0]    r_rows;
    logic [WIDTH_FEATURE_SIZE-1:0]    r_row;
    logic [WIDTH_FEATURE_SIZE-1:0]    r_col;
    logic [5:0]                       r_shift;
    logic [7:0]                       r_zp;
    logic                             r_pcnt;
    logic [BIAS_LAT-1:0]              r_vdly;
    logic [2:0]                       r_v;
    logic                             r_done;
    logic                             w_rd;
    logic                             w_degen;
    logic                             w_grp_last;
    logic                             w_last;
    logic                             w_empty;

    assign w_rd       = (r_state == S_READ);
    assign w_degen    = (Channel_Out_Num_REG < 10'd8)
                     || (Row_Num_Out_REG == '0);
    assign w_grp_last = (r_grp == r_ct - 1'b1);
    assign w_last     = w_grp_last && (r_row == r_rows - 1'b1);
    assign w_empty    = (r_vdly == '0) && (r_v == '0);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (Start) w_next = w_degen ? S_FIN : S_PARAM;
            S_PARAM: if (r_pcnt) w_next = S_WAIT;
            S_WAIT:  if (fifo_ready && M_Ready) w_next = S_READ;
            S_READ:  if (r_col == r_rows - 1'b1) w_next = S_DRAIN;
            S_DRAIN: if (w_empty) w_next = S_NEXT;
            S_NEXT:  w_next = w_last ? S_FIN : S_PARAM;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ct    <= '0;
            r_grp   <= '0;
            r_rows  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_shift <= '0;
            r_zp    <= '0;
            r_pcnt  <= 1'b0;
            r_vdly  <= '0;
            r_v     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_FIN);
            r_vdly  <= {r_vdly[BIAS_LAT-2:0], w_rd};
            r_v     <= {r_v[1:0], r_vdly[BIAS_LAT-1]};
            r_pcnt  <= (r_state == S_PARAM) ? ~r_pcnt : 1'b0;
            r_col   <= w_rd ? r_col + 1'b1 : '0;
            if (r_state == S_IDLE && Start) begin
                r_ct    <= Channel_Out_Num_REG >> 3;
                r_rows  <= Row_Num_Out_REG;
                r_shift <= Shift_REG;
                r_zp    <= Zero_Point_REG;
                r_grp   <= '0;
                r_row   <= '0;
            end
            if (r_state == S_NEXT) begin
                if (w_grp_last) begin
                    r_grp <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_grp <= r_grp + 1'b1;
                end
            end
        end
    end

    for (genvar j = 0; j < CHANNEL_OUT_NUM; j++) begin : g_ch
        for (genvar i = 0; i < PICTURE_NUM; i++) begin : g_pic
            localparam int L = j * PICTURE_NUM + i;
            conv_quant_ctrl_11_lane u_lane (
                .i_clk   (clk),
                .i_rst_n (rst),
                .i_en    ({r_v[1], r_v[0], r_vdly[BIAS_LAT-1]}),
                .i_data  (S_Data[L*WIDTH_DATA_ADD_TEMP +: WIDTH_DATA_ADD_TEMP]),
                .i_scale (Scale_Data_in[j*WIDTH_SCALE +: WIDTH_SCALE]),
                .i_shift (r_shift),
                .i_zp    (r_zp),
                .o_data  (M_Data[L*8 +: 8])
            );
        end
    end

    assign rd_en_fifo = w_rd;
    assign Param_Addr = r_grp;
    assign M_Valid    = r_v[2];
    assign Layer_Done = r_done;

endmodule

// File: doc/conv_quant_ctrl_11.md
Name: conv_quant_ctrl_11

Overview:
- Downstream neighbour of the 1x1-conv bias stage.
- Issues row-granular reads into the bias FIFO and drives the bias/scale parameter address per channel group.
- Takes the 48-bit biased accumulators and requantizes them to uint8: per-channel scale multiply, rounding right shift, zero-point add, clamp.
- Streams the 8-bit results to the output-feature FIFO with row-level backpressure.

Parameters:
- CHANNEL_OUT_NUM, 8, output channels per group (lanes per picture).
- WIDTH_FEATURE_SIZE, 12, width of row/column counters.
- WIDTH_DATA_ADD_TEMP, 48, signed input lane width.
- WIDTH_SCALE, 32, signed per-channel scale width.
- WIDTH_CHANNEL_NUM_REG, 10, width of channel-count register.
- BIAS_LAT, 2, cycles from rd_en_fifo to valid S_Data (FIFO read plus bias add).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- Start  in  1  one-cycle pulse; latches config and begins a layer.
- fifo_ready  in  1  bias FIFO holds at least one full row.
- rd_en_fifo  out  1  bias FIFO read strobe.
- S_Data  in  `PICTURE_NUM*CHANNEL_OUT_NUM*WIDTH_DATA_ADD_TEMP  biased accumulators; lane order j*`PICTURE_NUM+i.
- Param_Addr  out  WIDTH_CHANNEL_NUM_REG  channel-group index for the bias/scale ROM.
- Scale_Data_in  in  WIDTH_SCALE*CHANNEL_OUT_NUM  per-channel scales for the current Param_Addr.
- Shift_REG  in  6  right-shift amount, 0..47.
- Zero_Point_REG  in  8  unsigned zero point.
- Channel_Out_Num_REG  in  WIDTH_CHANNEL_NUM_REG  total output channels; multiple of 8.
- Row_Num_Out_REG  in  WIDTH_FEATURE_SIZE  feature width = height.
- M_Ready  in  1  output FIFO can accept one full row.
- M_Data  out  `PICTURE_NUM*CHANNEL_OUT_NUM*8  quantized lanes, same lane order as S_Data.
- M_Valid  out  1  M_Data valid.
- Layer_Done  out  1  one-cycle pulse after the last output beat.

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE. rd_en_fifo, M_Valid, Layer_Done, Param_Addr, M_Data and all counters and pipeline valids go to 0.
- Reset mid-layer aborts immediately. No output is produced after the reset edge.
- Config latch: on Start in IDLE, latch Channel_Times = Channel_Out_Num_REG>>3, Row_Num_Out_REG, Shift_REG and Zero_Point_REG. Start in any other state is ignored.
- Loop order: row_cnt 0..R-1 (outer), grp_cnt 0..Channel_Times-1 (inner). Each (row, group) is R consecutive beats. Param_Addr = grp_cnt.
- FSM:
  - IDLE -> PARAM on Start.
  - PARAM: hold 2 cycles so the ROM output settles, then -> WAIT.
  - WAIT -> READ when fifo_ready && M_Ready are both 1 in the same cycle.
  - READ: rd_en_fifo=1 for exactly R consecutive cycles, col_cnt 0..R-1, no gaps, then -> DRAIN.
  - DRAIN: wait until the input valid delay line and all 3 pipe stages are empty, then -> NEXT.
  - NEXT: advance grp_cnt. On wrap, clear grp_cnt and advance row_cnt.
  - NEXT -> PARAM, or -> IDLE with Layer_Done=1 after the last row/group.
- Input valid: rd_en_fifo delayed by BIAS_LAT via shift register.
- Pipeline, latency 3 from input valid to M_Valid:
  - P1: signed product p = S_lane * scale, 80-bit.
  - P2: r = (p + (Shift ? 1<<(Shift-1) : 0)) >>> Shift, arithmetic shift, round half up.
  - P3: q = r + zp; clamp to 0..255.
- Scale is stable throughout a group because PARAM/DRAIN isolate groups.
- Degenerate config: Channel_Out_Num_REG<8 or Row_Num_Out_REG=0 -> Layer_Done pulses 2 cycles after Start, with no reads.
- M_Ready and fifo_ready are sampled only in WAIT; the downstream guarantees row capacity.

Decomposition:
- Para.v (shared): `PICTURE_NUM, lane widths, state encodings.
- Sub-module quant_lane (P1-P3 for one lane), instantiated `PICTURE_NUM*CHANNEL_OUT_NUM times via generate.
- FSM and counters stay in the top.

Test Plan:
- R=4, 8 channels, fifo_ready/M_Ready held 1, Start.
  - Expect: 4 rows x 1 group = 16 rd_en cycles in 4 bursts of 4.
  - M_Valid exactly 5 cycles after each rd_en (BIAS_LAT 2 + 3).
  - Layer_Done after the final beat.
- Arithmetic: S=1000, scale=3, shift=4, zp=10 -> 3000 rounded >>4 = 188, +10 -> 198. S=-5000, same params -> 0 (clamp). S=100000 -> 255.
- Rounding: S=24, scale=1, shift=4 -> 2. S=23 -> 1. Shift=0, S=7, zp=0 -> 7.
- Channel_Out_Num_REG=16, R=2: Param_Addr sequence 0,1,0,1. Scale changed per address; each group's outputs use its own scale.
- fifo_ready=0 for 20 cycles in WAIT: no rd_en. Then fifo_ready=1 with M_Ready=0: still no rd_en. M_Ready=1: burst starts next cycle.
- rst=0 asserted mid-READ: rd_en_fifo, M_Valid and Layer_Done are 0 from the next edge. A fresh Start runs a full layer correctly.
